cpu_oci_dct_packer: RTL and testbench
=====================================

# cpu_oci_dct_packer

Packs the CPU's 2-bit direct-branch trace atoms into 30-bit frames of up to 15 atoms for the OCI trace path. It sits directly upstream of the OCI test bench: it exports the live `dct_buffer`/`dct_count` pair and drives the `test_has_ended` handshake that the bench watches. Completed frames go downstream through a one-deep valid/ready output register.

## Interface
- `ATOM_W`, 2, bits per trace atom
- `DEPTH`, 15, atoms per frame (`BUF_W` = 30, `CNT_W` = 4 derived)
- `clk` in 1 — sole clock
- `reset` in 1 — synchronous, active-high
- `atom_valid` in 1 — atom present this cycle
- `atom` in 2 — trace atom (00 not-taken, 01 taken, 10/11 reserved, packed as-is)
- `flush_req` in 1 — emit partial frame (exception/indirect branch)
- `frame_valid` out 1 — output register holds a frame
- `frame_ready` in 1 — downstream accepts frame
- `frame_data` out 30 — packed frame, atom k at bits [2k+1:2k]
- `frame_count` out 4 — atoms in frame, 1..15
- `dct_buffer` out 30 — live accumulator contents
- `dct_count` out 4 — live accumulator atom count, 0..15
- `overflow` out 1 — sticky; at least one atom was dropped
- `test_ending` in 1 — end-of-test request (level or pulse)
- `test_has_ended` out 1 — sticky; all trace drained after `test_ending`

## Operation
- Accumulator: the atom accepted when `dct_count` = k is written to slot k, and the count increments. Unused upper slots read 0.
- Frame close on either condition (including an atom accepted the same cycle):
  - count reaches 15, or
  - `flush_req` with a resulting count ≥ 1.
- Transfer: a closed frame moves to the output register when it is empty or being drained this cycle (`frame_valid && frame_ready`). The accumulator then clears to 0.
- Blocked close: the output register is occupied and not draining.
  - The accumulator holds its frame closed (full, or flushed-pending) and transfers on the first free cycle.
  - Atoms arriving while it is closed are dropped, and `overflow` is set.
- `flush_req` with count 0 and no atom: no effect.
- A pending flush merges with a later `flush_req`: still one frame.
- States:
  - RUN: normal.
  - DRAIN: entered on `test_ending`. Forces a flush and ignores all further atoms; they are not counted as overflow.
  - DONE: entered when the accumulator is empty and `frame_valid` = 0. Asserts `test_has_ended`.
  - DONE is terminal until reset.
- `reset` mid-operation discards the accumulator and the output frame. No partial frame is emitted.

## Timing
- Reset values: `frame_valid` 0, `frame_data` 0, `frame_count` 0, `dct_buffer` 0, `dct_count` 0, `overflow` 0, `test_has_ended` 0, state RUN.
- `dct_buffer`/`dct_count` update on the edge that accepts the atom.
- `frame_valid` rises one cycle after the closing atom or `flush_req` (transfer latency 1).
- `frame_data`/`frame_count` are stable while `frame_valid && !frame_ready`.
- Back-to-back full frames are sustained at 1 atom/cycle when `frame_ready` = 1.
- `test_has_ended` rises on the cycle after the last frame handshake. If nothing is buffered, it rises on the cycle after `test_ending`.
- `overflow` sets on the edge after the dropped atom.

## Structure
- Shared package: `ATOM_W`, `DEPTH`, `BUF_W`, `CNT_W`, atom encodings, and the state enum {RUN, DRAIN, DONE}.
- One natural sub-module: `cpu_oci_dct_outreg`, the one-deep valid/ready holding register (data + count).
- Accumulator and FSM live in the top.

## Test plan
- 15 consecutive atoms 01 with `frame_ready` = 1:
  - `frame_valid` for 1 cycle with `frame_data` = 0x15555555, `frame_count` = 15.
  - `dct_count` returns to 0.
- Atoms 01, 00, 01, then `flush_req`: `frame_data` = 0x11, `frame_count` = 3, one cycle after the flush.
- `frame_ready` = 0, 30 atoms, then a 31st:
  - The first frame is held.
  - The accumulator holds 15 atoms.
  - The 31st atom is dropped and `overflow` = 1.
  - Raising `frame_ready` drains both frames in order.
- `flush_req` with count 0: no frame is emitted and state is unchanged.
- 5 atoms, then `test_ending`:
  - Partial frame with `frame_count` = 5 is emitted.
  - Later atoms are ignored and `overflow` stays 0.
  - `test_has_ended` rises the cycle after the handshake and stays high.
- `reset` asserted with 7 atoms buffered and `frame_valid` = 1: all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/cpu_oci_dct_packer_pkg.sv
// Shared widths, atom encodings and FSM state codes for the OCI direct-branch trace packer.
// No logic of its own; no latency.
// Not applicable to backpressure (constants only).
package cpu_oci_dct_packer_pkg;

    localparam int ATOM_W = 2;
    localparam int DEPTH  = 15;
    localparam int BUF_W  = ATOM_W * DEPTH;
    localparam int CNT_W  = 4;

    // Atom encodings; 10/11 are reserved and packed unchanged
    localparam logic [ATOM_W-1:0] ATOM_NOT_TAKEN = 2'b00;
    localparam logic [ATOM_W-1:0] ATOM_TAKEN     = 2'b01;

    // Packer FSM state codes
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/cpu_oci_dct_outreg.sv
// One-deep valid/ready holding register for a packed trace frame and its atom count.
// Latency 1: a frame loaded on an edge is presented as frame_valid on the following cycle.
// Backpressure: accepts a load only when empty or draining this cycle; contents are stable while stalled.
module cpu_oci_dct_outreg
    import cpu_oci_dct_packer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_vld,
    input  logic [BUF_W-1:0] load_dat,
    input  logic [CNT_W-1:0] load_cnt,
    output logic             load_rdy,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [BUF_W-1:0] frame_data,
    output logic [CNT_W-1:0] frame_count
);

    assign load_rdy = !frame_valid || frame_ready;

    // Capture a new frame when offered, otherwise empty out after the downstream handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_valid <= 1'b0;
            frame_data  <= '0;
            frame_count <= '0;
        end else if (load_vld) begin
            frame_valid <= 1'b1;
            frame_data  <= load_dat;
            frame_count <= load_cnt;
        end else if (frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_oci_dct_packer.sv
// Packs 2-bit direct-branch trace atoms into 30-bit frames of up to 15 atoms, with end-of-test drain.
// Latency 1: frame_valid rises the cycle after the closing atom or flush; dct_* update on the accepting edge.
// Backpressure: a closed frame waits in the accumulator while the output is stalled; atoms arriving then are dropped and flagged in overflow.
module cpu_oci_dct_packer
    import cpu_oci_dct_packer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              atom_valid,
    input  logic [ATOM_W-1:0] atom,
    input  logic              flush_req,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic [BUF_W-1:0]  frame_data,
    output logic [CNT_W-1:0]  frame_count,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              overflow,
    input  logic              test_ending,
    output logic              test_has_ended
);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [BUF_W-1:0] acc_buf;
    logic [CNT_W-1:0] acc_cnt;
    logic             acc_closed;     // frame closed but still waiting for the output register

    logic [BUF_W-1:0] buf_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [BUF_W-1:0] buf_d;
    logic [CNT_W-1:0] cnt_d;
    logic             closed_d;
    logic             drain_act;
    logic             accept;
    logic             drop;
    logic             flush_eff;
    logic             close;
    logic             out_rdy;
    logic             xfer;
    logic             fv_nxt;
    logic             done_nxt;

    // Accumulator update, frame close/transfer decision and FSM next state
    always_comb begin
        // test_ending acts in the cycle it arrives so an empty packer finishes one cycle later
        drain_act = (state_q == ST_DRAIN) || ((state_q == ST_RUN) && test_ending);
        accept    = atom_valid && (state_q == ST_RUN) && !acc_closed;
        drop      = atom_valid && (state_q == ST_RUN) && acc_closed;
        flush_eff = flush_req || drain_act;

        buf_nxt = acc_buf;
        cnt_nxt = acc_cnt;
        if (accept) begin
            buf_nxt = acc_buf | (BUF_W'(atom) << (ATOM_W * int'(acc_cnt)));
            cnt_nxt = acc_cnt + CNT_W'(1);
        end

        close = acc_closed || (cnt_nxt == CNT_W'(DEPTH)) || (flush_eff && (cnt_nxt != '0));
        xfer  = close && out_rdy;

        buf_d    = buf_nxt;
        cnt_d    = cnt_nxt;
        closed_d = close;
        if (xfer) begin
            buf_d    = '0;
            cnt_d    = '0;
            closed_d = 1'b0;
        end

        fv_nxt   = xfer || (frame_valid && !frame_ready);
        done_nxt = (cnt_d == '0) && !fv_nxt;

        state_d = state_q;
        case (state_q)
            ST_RUN:   if (test_ending) state_d = done_nxt ? ST_DONE : ST_DRAIN;
            ST_DRAIN: if (done_nxt)    state_d = ST_DONE;
            default:  state_d = ST_DONE;
        endcase
    end

    // Register accumulator, sticky overflow and FSM state
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_buf    <= '0;
            acc_cnt    <= '0;
            acc_closed <= 1'b0;
            overflow   <= 1'b0;
            state_q    <= ST_RUN;
        end else begin
            acc_buf    <= buf_d;
            acc_cnt    <= cnt_d;
            acc_closed <= closed_d;
            state_q    <= state_d;
            if (drop) overflow <= 1'b1;
        end
    end

    cpu_oci_dct_outreg u_outreg (
        .clk         (clk),
        .reset       (reset),
        .load_vld    (xfer),
        .load_dat    (buf_nxt),
        .load_cnt    (cnt_nxt),
        .load_rdy    (out_rdy),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .frame_count (frame_count)
    );

    assign dct_buffer     = acc_buf;
    assign dct_count      = acc_cnt;
    assign test_has_ended = (state_q == ST_DONE);

endmodule

// File: tb/tb_cpu_oci_dct_packer.sv
// Directed self-checking bench for the OCI direct-branch trace packer.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
// Expected values are hand-computed constants.
module tb_cpu_oci_dct_packer;
    import cpu_oci_dct_packer_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             atom_valid;
    logic [ATOM_W-1:0] atom;
    logic             flush_req;
    logic             frame_valid;
    logic             frame_ready;
    logic [BUF_W-1:0] frame_data;
    logic [CNT_W-1:0] frame_count;
    logic [BUF_W-1:0] dct_buffer;
    logic [CNT_W-1:0] dct_count;
    logic             overflow;
    logic             test_ending;
    logic             test_has_ended;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    cpu_oci_dct_packer dut (
        .clk            (clk),
        .reset          (reset),
        .atom_valid     (atom_valid),
        .atom           (atom),
        .flush_req      (flush_req),
        .frame_valid    (frame_valid),
        .frame_ready    (frame_ready),
        .frame_data     (frame_data),
        .frame_count    (frame_count),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .overflow       (overflow),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then wait for the edge and settle
    task automatic step(input logic av, input logic [ATOM_W-1:0] a, input logic fl,
                        input logic te, input logic rdy, input logic rst);
        atom_valid  = av;
        atom        = a;
        flush_req   = fl;
        test_ending = te;
        frame_ready = rdy;
        reset       = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " frame_valid"},    32'(frame_valid),    32'd0);
        check({tag, " frame_data"},     32'(frame_data),     32'd0);
        check({tag, " frame_count"},    32'(frame_count),    32'd0);
        check({tag, " dct_buffer"},     32'(dct_buffer),     32'd0);
        check({tag, " dct_count"},      32'(dct_count),      32'd0);
        check({tag, " overflow"},       32'(overflow),       32'd0);
        check({tag, " test_has_ended"}, 32'(test_has_ended), 32'd0);
    endtask

    initial begin
        // Reset state
        step(1'b0, ATOM_NOT_TAKEN, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, ATOM_NOT_TAKEN, 1'b0, 1'b0, 1'b1, 1'b1);
        check_reset_values("reset");
        step(1'b0, ATOM_NOT_TAKEN, 1'b0, 1'b0, 1'b1, 1'b0);

        // 15 taken atoms with ready high close one full frame
        for (int i = 0; i < 14; i++) step(1'b1, ATOM_TAKEN, 1'b0, 1'b0, 1'b1, 1'b0);
        check("full14 dct_count", 32'(dct_count), 32'd14);
        check("full14 frame_valid", 32'(frame_valid), 32'd0);
        step(1'b1, ATOM_TAKEN, 1'b0, 1'b0, 1'b1, 1'b0);
        check("full frame_valid", 32'(frame_valid), 32'd1);
        check("full frame_data", 32'(frame_data), 32'h1555_5555);
        check("full frame_count", 32'(frame_count), 32'd15);
        check("full dct_count", 32'(dct_count), 32'd0);
        step(1'b0, ATOM_NOT_TAKEN, 1'b0, 1'b0, 1'b1, 1'b0);
        check("full one-cycle valid", 32'(frame_valid), 32'd0);

        // Partial frame 01,00,01 then flush
        step(1'b1, ATOM_TAKEN,     1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, ATOM_NOT_TAKEN, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, ATOM_TAKEN,     1'b0, 1'b0, 1'b1, 1'b0);
        check("part dct_buffer", 32'(dct_buffer), 32'h11);
        check("part dct_count", 32'(dct_count), 32'd3);
        check("part pre-flush valid", 32'(frame_valid), 32'd0);
        step(1'b0, ATOM_NOT_TAKEN, 1'b1, 1'b0, 1'b1, 1'b0);
        check("part frame_valid", 32'(frame_valid), 32'd1);
        check("part frame_data", 32'(frame_data), 32'h11);
        check("part frame_count", 32'(frame_count), 32'd3);
        check("part dct_count", 32'(dct_count), 32'd0);
        step(1'b0, ATOM_NOT_TAKEN, 1'b0, 1'b0, 1'b1, 1'b0);
        check("part valid drops", 32'(frame_valid), 32'd0);

        // Stalled output: two full frames (01s then reserved 10s), 31st atom dropped
        for (int i = 0; i < 15; i++) step(1'b1, ATOM_TAKEN, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b1, 2'b10,      1'b0, 1'b0, 1'b0, 1'b0);
        check("stall held valid", 32'(frame_valid), 32'd1);
        check("stall held data", 32'(frame_data), 32'h1555_5555);
        check("stall acc count", 32'(dct_count), 32'd15);
        check("stall acc buffer", 32'(dct_buffer), 32'h2AAA_AAAA);
        check("stall no overflow yet", 32'(overflow), 32'd0);
        step(1'b1, ATOM_TAKEN, 1'b0, 1'b0, 1'b0, 1'b0);
        check("stall overflow", 32'(overflow), 32'd1);
        check("stall drop count", 32'(dct_count), 32'd15);
        check("stall drop buffer", 32'(dct_buffer), 32'h2AAA_AAAA);
        check("stall data stable", 32'(frame_data), 32'h1555_5555);
        step(1'b0, ATOM_NOT_TAKEN, 1'b0, 1'b0, 1'b1, 1'b0);
        check("drain2 valid", 32'(frame_valid), 32'd1);
        check("drain2 data", 32'(frame_data), 32'h2AAA_AAAA);
        check("drain2 count", 32'(frame_count), 32'd15);
        check("drain2 acc empty", 32'(dct_count), 32'd0);
        step(1'b0, ATOM_NOT_TAKEN, 1'b0, 1'b0, 1'b1, 1'b0);
        check("drain2 done", 32'(frame_valid), 32'd0);
        check("overflow sticky", 32'(overflow), 32'd1);

        // Reset clears overflow; flush with empty accumulator does nothing
        step(1'b0, ATOM_NOT_TAKEN, 1'b0, 1'b0, 1'b1, 1'b1);
        check("reset2 overflow", 32'(overflow), 32'd0);
        step(1'b0, ATOM_NOT_TAKEN, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, ATOM_NOT_TAKEN, 1'b0, 1'b0, 1'b1, 1'b0);
        check("empty flush valid", 32'(frame_valid), 32'd0);
        check("empty flush count", 32'(dct_count), 32'd0);
        check("empty flush ended", 32'(test_has_ended), 32'd0);

        // Five atoms then test_ending with output stalled
        step(1'b1, ATOM_TAKEN,     1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, ATOM_TAKEN,     1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, ATOM_NOT_TAKEN, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, ATOM_TAKEN,     1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, ATOM_NOT_TAKEN, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, ATOM_NOT_TAKEN, 1'b0, 1'b1, 1'b0, 1'b0);
        check("end frame_valid", 32'(frame_valid), 32'd1);
        check("end frame_count", 32'(frame_count), 32'd5);
        check("end frame_data", 32'(frame_data), 32'h45);
        check("end not yet ended", 32'(test_has_ended), 32'd0);
        step(1'b1, ATOM_TAKEN, 1'b0, 1'b0, 1'b0, 1'b0);
        check("end atom ignored", 32'(dct_count), 32'd0);
        check("end no overflow", 32'(overflow), 32'd0);
        check("end still waiting", 32'(test_has_ended), 32'd0);
        step(1'b1, ATOM_TAKEN, 1'b0, 1'b0, 1'b1, 1'b0);
        check("end ended after handshake", 32'(test_has_ended), 32'd1);
        check("end valid cleared", 32'(frame_valid), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, ATOM_TAKEN, 1'b1, 1'b1, 1'b1, 1'b0);
        check("end ended sticky", 32'(test_has_ended), 32'd1);
        check("end later atoms ignored", 32'(dct_count), 32'd0);
        check("end later no overflow", 32'(overflow), 32'd0);
        check("end no new frame", 32'(frame_valid), 32'd0);

        // Reset with 7 atoms buffered and a frame held
        step(1'b0, ATOM_NOT_TAKEN, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, ATOM_TAKEN, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, ATOM_TAKEN, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, ATOM_TAKEN, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pre-reset valid", 32'(frame_valid), 32'd1);
        check("pre-reset count", 32'(dct_count), 32'd7);
        check("pre-reset frame_count", 32'(frame_count), 32'd2);
        step(1'b0, ATOM_NOT_TAKEN, 1'b0, 1'b0, 1'b0, 1'b1);
        check_reset_values("midreset");
        step(1'b0, ATOM_NOT_TAKEN, 1'b0, 1'b0, 1'b1, 1'b0);
        check("no partial after reset", 32'(frame_valid), 32'd0);

        // test_ending with nothing buffered ends on the next cycle
        step(1'b0, ATOM_NOT_TAKEN, 1'b0, 1'b1, 1'b1, 1'b0);
        check("empty end ended", 32'(test_has_ended), 32'd1);
        check("empty end no frame", 32'(frame_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
